ctrl_unit: RTL and testbench
============================

Name: ctrl_unit

Overview:
- Multi-cycle fetch/decode/execute sequencer for the accumulator-based matrix-multiply processor.
- Fetches 17-bit instructions ({opcode[4:0], addr[11:0]}) from the instruction memory, which has 1-cycle read latency.
- Decodes each instruction and drives one-cycle control strobes into the datapath (AC, R, AR, R1..R4, ALU, data memory).
- Sequences conditional jumps from the datapath Z flag; runs from `start` until a HALT opcode.

Parameters:
- ADDR_W, 12, PC, instruction-address and data-address width.
- OP_W, 5, opcode width.
- INSTR_W, 17, instruction width (OP_W+ADDR_W).
- RESET_PC, 0, PC value after reset and on `start`.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; in IDLE/HALT loads PC=RESET_PC and begins fetching.
- imem_re  out  1  instruction memory read enable.
- imem_addr  out  ADDR_W  instruction address (= PC).
- imem_data  in  INSTR_W  instruction word, valid the cycle after imem_re.
- z_flag  in  1  datapath zero flag (AC==0), registered in datapath.
- ac_we  out  1  AC load strobe.
- ac_src  out  3  AC source: 0 ALU, 1 DMEM, 2..5 R1..R4.
- alu_op  out  3  0 ADD, 1 SUB (AC-R), 2 MULT, 3 LSHIFT (AC<<1), 4 INC (AC+1).
- r_we, ar_we  out  1 each  load R / AR from AC.
- rn_we  out  4  one-hot load of R1..R4 from AC.
- dmem_re, dmem_we  out  1 each  data memory read / write.
- dmem_addr_sel  out  1  0 = imm_addr, 1 = AR.
- imm_addr  out  ADDR_W  IR address field.
- busy  out  1  high from accepted start until HALT.
- done  out  1  sticky high in HALT, cleared by start.
- illegal  out  1  sticky; set on undefined opcode, cleared by start.

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE, PC=RESET_PC, IR=0.
  - All strobes 0; busy, done, illegal = 0; imm_addr = 0.
- States:
  - IDLE/HALT: wait for start.
  - FETCH: imem_re=1, imem_addr=PC.
  - LOAD: IR<=imem_data, PC<=PC+1 (wraps mod 2^ADDR_W).
  - EXEC: strobes from IR opcode, one cycle.
  - MEMWB: loads only.
  - Transitions: EXEC→FETCH (or MEMWB, HALT); MEMWB→FETCH.
- Latency: 3 cycles per instruction; ldac/ldiac take 4.
- Opcode decode:
  - 0 HALT: busy=0, done=1.
  - 1 nop: no strobes.
  - 2 mvacar: ar_we.
  - 3 mvac: r_we.
  - 4..7 mvacr1..4: rn_we one-hot.
  - 8..11 mvr1ac..mvr4ac: ac_we, ac_src=2..5.
  - 12 ldac: dmem_re, sel=AR in EXEC; ac_we, ac_src=1 in MEMWB.
  - 13 ldiac: as ldac with sel=imm.
  - 14 stac: dmem_we, sel=imm.
  - 15 add, 16 mult, 17 lshift, 18 sub, 19 inac: ac_we, ac_src=0, alu_op per table.
  - 20 jpnz: if z_flag==0, PC<=addr.
  - 21 jmpz: if z_flag==1, PC<=addr.
  - 22..31: treated as nop, illegal<=1.
- z_flag is sampled in EXEC; the preceding instruction has fully retired, so Z is current.
- Jump-taken overrides the LOAD-stage increment (PC written in EXEC). Target 0 is legal.
- start while busy is ignored. start in the same cycle as reset release: reset wins.
- Reset mid-instruction aborts immediately; no strobe survives into the reset cycle.
- Strobes are registered outputs, asserted exactly one cycle, never simultaneously for conflicting destinations.

Decomposition:
- Package ctrl_pkg holds:
  - opcode localparams (HALT..jmpz);
  - alu_op and ac_src encodings;
  - state enum;
  - field-slice constants OP_MSB/OP_LSB.
- Shared with the datapath and the assembler-style program ROM init.
- One sub-module, ctrl_decode: purely combinational opcode→strobe vector.
- The FSM/PC logic stays in ctrl_unit.

Test Plan:
- Reset then start, ROM {nop, HALT}:
  - imem_addr 0,1 on FETCH cycles;
  - done=1 on cycle 7 after start; busy falls the same cycle.
- ROM {ldiac 3, mvac, HALT}:
  - dmem_re with imm_addr=3 in EXEC;
  - ac_we+ac_src=1 one cycle later;
  - then r_we single-cycle pulse.
- ROM {jpnz 5, ...}:
  - z_flag=0 → next imem_addr=5;
  - z_flag=1 → next imem_addr=1.
  - Repeat with jmpz for the inverse.
- Opcode 25 at PC 0 → illegal=1 and no strobes; execution continues to PC 1. A subsequent start clears illegal.
- rst_n low during the MEMWB of ldac:
  - ac_we never asserts;
  - all outputs 0 asynchronously;
  - PC=0 after release.
- PC wrap: start with PC at 4095 (RESET_PC=4095), nop → next fetch address 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared encodings for the matrix-multiply processor sequencer:
//               opcodes, ALU/AC-source selects, FSM states, decode vector.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    // Opcode field position inside the 17-bit instruction word
    localparam int OP_MSB = 16;
    localparam int OP_LSB = 12;

    // Opcodes
    localparam logic [4:0] OP_HALT   = 5'd0;
    localparam logic [4:0] OP_NOP    = 5'd1;
    localparam logic [4:0] OP_MVACAR = 5'd2;
    localparam logic [4:0] OP_MVAC   = 5'd3;
    localparam logic [4:0] OP_MVACR1 = 5'd4;
    localparam logic [4:0] OP_MVACR2 = 5'd5;
    localparam logic [4:0] OP_MVACR3 = 5'd6;
    localparam logic [4:0] OP_MVACR4 = 5'd7;
    localparam logic [4:0] OP_MVR1AC = 5'd8;
    localparam logic [4:0] OP_MVR2AC = 5'd9;
    localparam logic [4:0] OP_MVR3AC = 5'd10;
    localparam logic [4:0] OP_MVR4AC = 5'd11;
    localparam logic [4:0] OP_LDAC   = 5'd12;
    localparam logic [4:0] OP_LDIAC  = 5'd13;
    localparam logic [4:0] OP_STAC   = 5'd14;
    localparam logic [4:0] OP_ADD    = 5'd15;
    localparam logic [4:0] OP_MULT   = 5'd16;
    localparam logic [4:0] OP_LSHIFT = 5'd17;
    localparam logic [4:0] OP_SUB    = 5'd18;
    localparam logic [4:0] OP_INAC   = 5'd19;
    localparam logic [4:0] OP_JPNZ   = 5'd20;
    localparam logic [4:0] OP_JMPZ   = 5'd21;

    // ALU operation select
    localparam logic [2:0] ALU_ADD    = 3'd0;
    localparam logic [2:0] ALU_SUB    = 3'd1;
    localparam logic [2:0] ALU_MULT   = 3'd2;
    localparam logic [2:0] ALU_LSHIFT = 3'd3;
    localparam logic [2:0] ALU_INC    = 3'd4;

    // AC load source select
    localparam logic [2:0] AC_SRC_ALU  = 3'd0;
    localparam logic [2:0] AC_SRC_DMEM = 3'd1;
    localparam logic [2:0] AC_SRC_R1   = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_MEMWB = 3'd4,
        ST_HALT  = 3'd5
    } state_e;

    // Decoded view of one opcode
    typedef struct packed {
        logic       ac_we;
        logic [2:0] ac_src;
        logic [2:0] alu_op;
        logic       r_we;
        logic       ar_we;
        logic [3:0] rn_we;
        logic       dmem_re;
        logic       dmem_we;
        logic       dmem_sel;   // 1 = AR, 0 = immediate
        logic       mem_load;   // needs a MEMWB cycle
        logic       halt;
        logic       jpnz;
        logic       jmpz;
        logic       illegal;
    } dec_t;

    localparam int DEC_W = $bits(dec_t);

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_decode
// Description : Purely combinational opcode to control-strobe decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OP_W = 5
) (
    input  logic [OP_W-1:0]  op_i,
    output logic [DEC_W-1:0] dec_o
);

    dec_t w_dec;

    // Map each opcode onto its strobe set; undefined opcodes behave as nop
    always_comb begin
        w_dec = '0;
        case (op_i)
            OP_HALT:   w_dec.halt  = 1'b1;
            OP_NOP:    ;
            OP_MVACAR: w_dec.ar_we = 1'b1;
            OP_MVAC:   w_dec.r_we  = 1'b1;
            OP_MVACR1, OP_MVACR2, OP_MVACR3, OP_MVACR4:
                w_dec.rn_we = 4'b0001 << op_i[1:0];
            OP_MVR1AC, OP_MVR2AC, OP_MVR3AC, OP_MVR4AC: begin
                w_dec.ac_we  = 1'b1;
                w_dec.ac_src = AC_SRC_R1 + {1'b0, op_i[1:0]};
            end
            OP_LDAC: begin
                w_dec.dmem_re  = 1'b1;
                w_dec.dmem_sel = 1'b1;
                w_dec.mem_load = 1'b1;
            end
            OP_LDIAC: begin
                w_dec.dmem_re  = 1'b1;
                w_dec.mem_load = 1'b1;
            end
            OP_STAC:   w_dec.dmem_we = 1'b1;
            OP_ADD:    begin w_dec.ac_we = 1'b1; w_dec.alu_op = ALU_ADD;    end
            OP_MULT:   begin w_dec.ac_we = 1'b1; w_dec.alu_op = ALU_MULT;   end
            OP_LSHIFT: begin w_dec.ac_we = 1'b1; w_dec.alu_op = ALU_LSHIFT; end
            OP_SUB:    begin w_dec.ac_we = 1'b1; w_dec.alu_op = ALU_SUB;    end
            OP_INAC:   begin w_dec.ac_we = 1'b1; w_dec.alu_op = ALU_INC;    end
            OP_JPNZ:   w_dec.jpnz = 1'b1;
            OP_JMPZ:   w_dec.jmpz = 1'b1;
            default:   w_dec.illegal = 1'b1;
        endcase
    end

    assign dec_o = w_dec;

endmodule
`default_nettype wire

// File: rtl/ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_unit
// Description : Fetch/load/execute sequencer with registered control strobes
//               for the accumulator-based matrix-multiply processor.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int OP_W     = 5,
    parameter int INSTR_W  = 17,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    output logic               imem_re_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic [INSTR_W-1:0] imem_data_i,
    input  logic               z_flag_i,
    output logic               ac_we_o,
    output logic [2:0]         ac_src_o,
    output logic [2:0]         alu_op_o,
    output logic               r_we_o,
    output logic               ar_we_o,
    output logic [3:0]         rn_we_o,
    output logic               dmem_re_o,
    output logic               dmem_we_o,
    output logic               dmem_addr_sel_o,
    output logic [ADDR_W-1:0]  imm_addr_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               illegal_o
);

    localparam logic [ADDR_W-1:0] c_RESET_PC = ADDR_W'(RESET_PC);

    state_e             state_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [INSTR_W-1:0] ir_q;
    logic               imem_re_q, ac_we_q, r_we_q, ar_we_q;
    logic [2:0]         ac_src_q, alu_op_q;
    logic [3:0]         rn_we_q;
    logic               dmem_re_q, dmem_we_q, dmem_sel_q;
    logic               busy_q, done_q, illegal_q;

    // One decoder serves both stages: the incoming word during LOAD (to
    // register the EXEC strobes) and the held IR during EXEC (for flow control)
    logic [OP_W-1:0]  w_dec_op;
    logic [DEC_W-1:0] w_dec_bits;
    dec_t             w_dec;

    assign w_dec_op = (state_q == ST_EXEC) ? ir_q[OP_MSB:OP_LSB]
                                           : imem_data_i[OP_MSB:OP_LSB];
    assign w_dec    = dec_t'(w_dec_bits);

    ctrl_decode #(
        .OP_W (OP_W)
    ) u_decode (
        .op_i  (w_dec_op),
        .dec_o (w_dec_bits)
    );

    // Sequencer: every strobe defaults low so each pulse lasts one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= c_RESET_PC;
            ir_q       <= '0;
            imem_re_q  <= 1'b0;
            ac_we_q    <= 1'b0;
            ac_src_q   <= '0;
            alu_op_q   <= '0;
            r_we_q     <= 1'b0;
            ar_we_q    <= 1'b0;
            rn_we_q    <= '0;
            dmem_re_q  <= 1'b0;
            dmem_we_q  <= 1'b0;
            dmem_sel_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            imem_re_q  <= 1'b0;
            ac_we_q    <= 1'b0;
            ac_src_q   <= '0;
            alu_op_q   <= '0;
            r_we_q     <= 1'b0;
            ar_we_q    <= 1'b0;
            rn_we_q    <= '0;
            dmem_re_q  <= 1'b0;
            dmem_we_q  <= 1'b0;
            dmem_sel_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_HALT: begin
                    if (start_i) begin
                        state_q   <= ST_FETCH;
                        pc_q      <= c_RESET_PC;
                        imem_re_q <= 1'b1;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        illegal_q <= 1'b0;
                    end
                end
                ST_FETCH: state_q <= ST_LOAD;
                ST_LOAD: begin
                    // Instruction word is on the bus now; strobes go out in EXEC
                    state_q    <= ST_EXEC;
                    ir_q       <= imem_data_i;
                    pc_q       <= pc_q + ADDR_W'(1);
                    ac_we_q    <= w_dec.ac_we;
                    ac_src_q   <= w_dec.ac_src;
                    alu_op_q   <= w_dec.alu_op;
                    r_we_q     <= w_dec.r_we;
                    ar_we_q    <= w_dec.ar_we;
                    rn_we_q    <= w_dec.rn_we;
                    dmem_re_q  <= w_dec.dmem_re;
                    dmem_we_q  <= w_dec.dmem_we;
                    dmem_sel_q <= w_dec.dmem_sel;
                    illegal_q  <= illegal_q | w_dec.illegal;
                end
                ST_EXEC: begin
                    if (w_dec.halt) begin
                        state_q <= ST_HALT;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (w_dec.mem_load) begin
                        state_q  <= ST_MEMWB;
                        ac_we_q  <= 1'b1;
                        ac_src_q <= AC_SRC_DMEM;
                    end else begin
                        state_q   <= ST_FETCH;
                        imem_re_q <= 1'b1;
                        // Taken jump overrides the increment done in LOAD
                        if ((w_dec.jpnz && !z_flag_i) || (w_dec.jmpz && z_flag_i))
                            pc_q <= ir_q[ADDR_W-1:0];
                    end
                end
                ST_MEMWB: begin
                    state_q   <= ST_FETCH;
                    imem_re_q <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign imem_re_o       = imem_re_q;
    assign imem_addr_o     = pc_q;
    assign ac_we_o         = ac_we_q;
    assign ac_src_o        = ac_src_q;
    assign alu_op_o        = alu_op_q;
    assign r_we_o          = r_we_q;
    assign ar_we_o         = ar_we_q;
    assign rn_we_o         = rn_we_q;
    assign dmem_re_o       = dmem_re_q;
    assign dmem_we_o       = dmem_we_q;
    assign dmem_addr_sel_o = dmem_sel_q;
    assign imm_addr_o      = ir_q[ADDR_W-1:0];
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign illegal_o       = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctrl_unit
// Description : Directed self-checking bench for ctrl_unit, with a second
//               instance at RESET_PC=4095 for PC wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst_n, start, start_w, z_flag;
    logic        imem_re, ac_we, r_we, ar_we, dmem_re, dmem_we, dmem_sel;
    logic        busy, done, illegal;
    logic [11:0] imem_addr, imm_addr;
    logic [16:0] imem_data;
    logic [2:0]  ac_src, alu_op;
    logic [3:0]  rn_we;

    logic        imem_re_w, ac_we_w, r_we_w, ar_we_w, dmem_re_w, dmem_we_w, dmem_sel_w;
    logic        busy_w, done_w, illegal_w;
    logic [11:0] imem_addr_w, imm_addr_w;
    logic [16:0] imem_data_w;
    logic [2:0]  ac_src_w, alu_op_w;
    logic [3:0]  rn_we_w;

    logic [16:0] rom   [0:15];
    logic [16:0] rom_w [0:15];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Instruction memories with one-cycle read latency
    always @(posedge clk) if (imem_re)   imem_data   <= rom[imem_addr[3:0]];
    always @(posedge clk) if (imem_re_w) imem_data_w <= rom_w[imem_addr_w[3:0]];

    ctrl_unit u_dut (
        .clk(clk), .rst_n(rst_n), .start_i(start),
        .imem_re_o(imem_re), .imem_addr_o(imem_addr), .imem_data_i(imem_data),
        .z_flag_i(z_flag), .ac_we_o(ac_we), .ac_src_o(ac_src), .alu_op_o(alu_op),
        .r_we_o(r_we), .ar_we_o(ar_we), .rn_we_o(rn_we),
        .dmem_re_o(dmem_re), .dmem_we_o(dmem_we), .dmem_addr_sel_o(dmem_sel),
        .imm_addr_o(imm_addr), .busy_o(busy), .done_o(done), .illegal_o(illegal)
    );

    ctrl_unit #(.RESET_PC(4095)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .start_i(start_w),
        .imem_re_o(imem_re_w), .imem_addr_o(imem_addr_w), .imem_data_i(imem_data_w),
        .z_flag_i(1'b0), .ac_we_o(ac_we_w), .ac_src_o(ac_src_w), .alu_op_o(alu_op_w),
        .r_we_o(r_we_w), .ar_we_o(ar_we_w), .rn_we_o(rn_we_w),
        .dmem_re_o(dmem_re_w), .dmem_we_o(dmem_we_w), .dmem_addr_sel_o(dmem_sel_w),
        .imm_addr_o(imm_addr_w), .busy_o(busy_w), .done_o(done_w), .illegal_o(illegal_w)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at the negedge of the first FETCH cycle
    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(tag, done, 1);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 17'd0;
    endtask

    function automatic logic [8:0] strobes();
        return {ac_we, r_we, ar_we, rn_we, dmem_re, dmem_we};
    endfunction

    initial begin
        logic [4:0] op;
        logic       taken;

        rst_n = 1'b0; start = 1'b0; start_w = 1'b0; z_flag = 1'b0;
        clear_rom();
        for (int i = 0; i < 16; i++) rom_w[i] = 17'd0;
        tick(2);
        check("rst_strobes", {imem_re, strobes()}, 0);
        check("rst_flags", {busy, done, illegal}, 0);
        check("rst_imm", imm_addr, 0);
        check("rst_pc", imem_addr, 0);
        check("rst_pc_wrap", imem_addr_w, 12'd4095);
        rst_n = 1'b1;

        // {nop, HALT}
        rom[0] = {5'd1, 12'd0};
        pulse_start();
        check("t1_fetch0", {imem_re, imem_addr}, {1'b1, 12'd0});
        check("t1_busy", busy, 1);
        tick(1);
        check("t1_re_load", imem_re, 0);
        tick(2);
        check("t1_fetch1", {imem_re, imem_addr}, {1'b1, 12'd1});
        tick(2);
        check("t1_c6", {busy, done}, 2'b10);
        tick(1);
        check("t1_c7", {busy, done}, 2'b01);

        // {ldiac 3, mvac, HALT}
        clear_rom();
        rom[0] = {5'd13, 12'd3};
        rom[1] = {5'd3, 12'd0};
        pulse_start();
        check("t2_done_clr", done, 0);
        tick(2);
        check("t2_ex", {dmem_re, dmem_sel, ac_we}, 3'b100);
        check("t2_imm", imm_addr, 3);
        tick(1);
        check("t2_wb", {ac_we, ac_src, dmem_re}, {1'b1, 3'd1, 1'b0});
        tick(3);
        check("t2_rwe", r_we, 1);
        tick(1);
        check("t2_rwe_off", {r_we, imem_addr}, {1'b0, 12'd2});
        wait_done("t2_done");

        // {sub, mvacr3, mvr2ac, stac 7, mvacar, HALT}
        clear_rom();
        rom[0] = {5'd18, 12'd0};
        rom[1] = {5'd6, 12'd0};
        rom[2] = {5'd9, 12'd0};
        rom[3] = {5'd14, 12'd7};
        rom[4] = {5'd2, 12'd0};
        pulse_start();
        tick(2);
        check("t3_sub", {ac_we, ac_src, alu_op}, {1'b1, 3'd0, 3'd1});
        tick(3);
        check("t3_mvacr3", {ac_we, rn_we}, {1'b0, 4'b0100});
        tick(3);
        check("t3_mvr2ac", {ac_we, ac_src}, {1'b1, 3'd3});
        tick(3);
        check("t3_stac", {dmem_we, dmem_re, dmem_sel}, 3'b100);
        check("t3_stac_imm", imm_addr, 7);
        tick(3);
        check("t3_mvacar", {ar_we, r_we}, 2'b10);
        wait_done("t3_done");

        // jpnz/jmpz to 5 under both Z values
        for (int i = 0; i < 4; i++) begin
            op     = (i < 2) ? 5'd20 : 5'd21;
            z_flag = i[0];
            taken  = (i < 2) ? !z_flag : z_flag;
            clear_rom();
            rom[0] = {op, 12'd5};
            pulse_start();
            tick(3);
            check($sformatf("t4_jump%0d", i), imem_addr, taken ? 12'd5 : 12'd1);
            wait_done($sformatf("t4_done%0d", i));
        end
        z_flag = 1'b0;

        // undefined opcode 25
        clear_rom();
        rom[0] = {5'd25, 12'd0};
        pulse_start();
        tick(2);
        check("t5_illegal", illegal, 1);
        check("t5_nostrobe", strobes(), 0);
        tick(1);
        check("t5_next", imem_addr, 1);
        wait_done("t5_done");
        check("t5_sticky", illegal, 1);
        rom[0] = 17'd0;
        pulse_start();
        check("t5_clr", illegal, 0);
        wait_done("t5_done2");

        // reset during MEMWB of ldac
        rom[0] = {5'd12, 12'd0};
        pulse_start();
        tick(2);
        check("t6_ex", {dmem_re, dmem_sel}, 2'b11);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t6_async", {imem_re, strobes(), busy}, 0);
        check("t6_pc_async", imem_addr, 0);
        @(negedge clk);
        check("t6_acwe", ac_we, 0);
        rst_n = 1'b1;
        tick(1);
        check("t6_idle", {busy, imem_re, imem_addr}, 0);
        clear_rom();
        pulse_start();
        check("t6_refetch", {imem_re, imem_addr}, {1'b1, 12'd0});
        wait_done("t6_done");

        // PC wrap on the RESET_PC=4095 instance
        rom_w[15] = {5'd1, 12'd0};
        @(negedge clk) start_w = 1'b1;
        @(negedge clk) start_w = 1'b0;
        check("t7_fetch", {imem_re_w, imem_addr_w}, {1'b1, 12'd4095});
        tick(3);
        check("t7_wrap", {imem_re_w, imem_addr_w}, {1'b1, 12'd0});
        tick(3);
        check("t7_done", {done_w, busy_w, illegal_w}, 3'b100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
